// File: rtl/clock_divider_bank.sv
// ----------------------------------------------------------------------------
// clock_divider_bank
//
// Bank of NUM_CH independent clock-enable generators running off CLOCK_50.
// Each channel holds a programmable divisor and counts active cycles from 0 up
// to that divisor. On reaching it, the channel issues a one-cycle tick and
// restarts. In free-running mode clk_out toggles on every tick, giving a 50%
// duty square wave of period 2*(div+1). In one-shot mode the channel ticks once
// after being armed by a configuration write and then goes idle.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   cfg_we       in   configuration write strobe (one cycle)
//   cfg_ch       in   [CH_W]       channel addressed by the write
//   cfg_div      in   [CNT_WIDTH]  new divisor
//   cfg_oneshot  in   write mode: 1 = one-shot, 0 = free-running
//   ch_enable    in   [NUM_CH]     per-channel run enable (level)
//   sync_clear   in   synchronous clear of counters and outputs
//   tick         out  [NUM_CH]     one-cycle strobe at terminal count
//   clk_out      out  [NUM_CH]     divided square wave
//   armed        out  [NUM_CH]     one-shot channel still pending
//
// All outputs are registered.
// ----------------------------------------------------------------------------
module clock_divider_bank #(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 10,
    parameter int DEFAULT_DIV = 217,
    parameter int CH_W        = 2
) (
    input  logic                 CLOCK_50,
    input  logic                 reset_n,
    input  logic                 cfg_we,
    input  logic [CH_W-1:0]      cfg_ch,
    input  logic [CNT_WIDTH-1:0] cfg_div,
    input  logic                 cfg_oneshot,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic                 sync_clear,
    output logic [NUM_CH-1:0]    tick,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    armed
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(i);

        logic [CNT_WIDTH-1:0] div_q;
        logic [CNT_WIDTH-1:0] count_q;
        logic                 mode_q;
        logic                 tick_q;
        logic                 clk_q;
        logic                 armed_q;

        logic                 wr_hit;
        logic                 active;
        logic                 at_terminal;

        // Indices at or beyond NUM_CH never match any channel, so such
        // writes fall through with no effect.
        assign wr_hit      = cfg_we && (cfg_ch == CH_IDX);
        assign active      = ch_enable[i] && (!mode_q || armed_q);
        assign at_terminal = (count_q == div_q);

        always_ff @(posedge CLOCK_50 or negedge reset_n) begin
            if (!reset_n) begin
                div_q   <= CNT_WIDTH'(DEFAULT_DIV);
                mode_q  <= 1'b0;
                count_q <= '0;
                tick_q  <= 1'b0;
                clk_q   <= 1'b0;
                armed_q <= 1'b0;
            end else if (sync_clear) begin
                // A coincident write still updates the divisor and mode,
                // but the clear keeps the channel disarmed.
                count_q <= '0;
                tick_q  <= 1'b0;
                clk_q   <= 1'b0;
                armed_q <= 1'b0;
                if (wr_hit) begin
                    div_q  <= cfg_div;
                    mode_q <= cfg_oneshot;
                end
            end else if (wr_hit) begin
                // The write overrides a terminal count on the same cycle,
                // so no tick is issued. clk_out keeps its phase.
                div_q   <= cfg_div;
                mode_q  <= cfg_oneshot;
                count_q <= '0;
                tick_q  <= 1'b0;
                armed_q <= cfg_oneshot;
            end else if (active) begin
                if (at_terminal) begin
                    count_q <= '0;
                    tick_q  <= 1'b1;
                    if (mode_q) begin
                        armed_q <= 1'b0;
                    end else begin
                        clk_q <= ~clk_q;
                    end
                end else begin
                    count_q <= count_q + CNT_WIDTH'(1);
                    tick_q  <= 1'b0;
                end
            end else begin
                // Paused or finished: hold count and clk_out.
                tick_q <= 1'b0;
            end
        end

        assign tick[i]    = tick_q;
        assign clk_out[i] = clk_q;
        assign armed[i]   = armed_q;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
module tb_clock_divider_bank;

    localparam int NUM_CH      = 4;
    localparam int CNT_WIDTH   = 10;
    localparam int DEFAULT_DIV = 217;
    localparam int CH_W        = 3;

    logic                 CLOCK_50 = 1'b0;
    logic                 reset_n;
    logic                 cfg_we;
    logic [CH_W-1:0]      cfg_ch;
    logic [CNT_WIDTH-1:0] cfg_div;
    logic                 cfg_oneshot;
    logic [NUM_CH-1:0]    ch_enable;
    logic                 sync_clear;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    clk_out;
    logic [NUM_CH-1:0]    armed;

    int errors = 0;
    int checks = 0;

    // Reference model: per channel, the number of active cycles still to go
    // until the next tick (a countdown from div+1).
    int m_div   [NUM_CH];
    int m_rem   [NUM_CH];
    bit m_mode  [NUM_CH];
    bit m_clk   [NUM_CH];
    bit m_armed [NUM_CH];
    bit m_tick  [NUM_CH];

    clock_divider_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_WIDTH   (CNT_WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV),
        .CH_W        (CH_W)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
        .cfg_oneshot (cfg_oneshot),
        .ch_enable   (ch_enable),
        .sync_clear  (sync_clear),
        .tick        (tick),
        .clk_out     (clk_out),
        .armed       (armed)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = DEFAULT_DIV;
            m_rem[i]   = DEFAULT_DIV + 1;
            m_mode[i]  = 1'b0;
            m_clk[i]   = 1'b0;
            m_armed[i] = 1'b0;
            m_tick[i]  = 1'b0;
        end
    endtask

    // Advance the model by one rising edge using the currently driven inputs.
    task automatic model_step();
        bit wr;
        for (int i = 0; i < NUM_CH; i++) begin
            wr = cfg_we && (int'(cfg_ch) == i);
            if (!reset_n) begin
                // handled by model_reset
            end else if (sync_clear) begin
                if (wr) begin
                    m_div[i]  = int'(cfg_div);
                    m_mode[i] = cfg_oneshot;
                end
                m_rem[i]   = m_div[i] + 1;
                m_clk[i]   = 1'b0;
                m_armed[i] = 1'b0;
                m_tick[i]  = 1'b0;
            end else if (wr) begin
                m_div[i]   = int'(cfg_div);
                m_mode[i]  = cfg_oneshot;
                m_rem[i]   = m_div[i] + 1;
                m_armed[i] = cfg_oneshot;
                m_tick[i]  = 1'b0;
            end else if (ch_enable[i] && (!m_mode[i] || m_armed[i])) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_rem[i]  = m_div[i] + 1;
                    if (m_mode[i]) m_armed[i] = 1'b0;
                    else           m_clk[i]   = ~m_clk[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
            end else begin
                m_tick[i] = 1'b0;
            end
        end
        if (!reset_n) model_reset();
    endtask

    task automatic check_outputs(input string tag);
        logic [NUM_CH-1:0] et, ec, ea;
        for (int i = 0; i < NUM_CH; i++) begin
            et[i] = m_tick[i];
            ec[i] = m_clk[i];
            ea[i] = m_armed[i];
        end
        chk({tag, ".tick"},    32'(tick),    32'(et));
        chk({tag, ".clk_out"}, 32'(clk_out), 32'(ec));
        chk({tag, ".armed"},   32'(armed),   32'(ea));
    endtask

    // One clock: model consumes the driven inputs, DUT takes the edge,
    // outputs are sampled 1 ns later. Strobes drop afterwards.
    task automatic cycle();
        model_step();
        @(posedge CLOCK_50);
        #1;
        check_outputs("cyc");
        cfg_we     = 1'b0;
        sync_clear = 1'b0;
    endtask

    // Run cycles until tick[ch] is seen; n returns the edge count (0 = timeout).
    task automatic cycles_to_tick(input int ch, input int limit, output int n);
        n = 0;
        for (int k = 1; k <= limit; k++) begin
            cycle();
            if (tick[ch]) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;

        reset_n     = 1'b0;
        cfg_we      = 1'b0;
        cfg_ch      = '0;
        cfg_div     = '0;
        cfg_oneshot = 1'b0;
        ch_enable   = '0;
        sync_clear  = 1'b0;
        model_reset();

        // Reset state
        #5;
        chk("reset.tick",    32'(tick),    32'h0);
        chk("reset.clk_out", 32'(clk_out), 32'h0);
        chk("reset.armed",   32'(armed),   32'h0);
        repeat (2) cycle();
        reset_n = 1'b1;

        // Channel 0 at the default divisor
        ch_enable = 4'b0001;
        cycles_to_tick(0, 300, n);
        chk("ch0.first_tick", 32'(n), 32'd218);
        chk("ch0.clk_after_first", 32'(clk_out[0]), 32'd1);
        cycles_to_tick(0, 300, n);
        chk("ch0.tick_period", 32'(n), 32'd218);
        chk("ch0.clk_after_second", 32'(clk_out[0]), 32'd0);

        // Channel 1 free-running, div 3
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 10'd3; cfg_oneshot = 1'b0;
        cycle();
        ch_enable = 4'b0011;
        cycles_to_tick(1, 20, n);
        cycles_to_tick(1, 20, n);
        chk("ch1.tick_period", 32'(n), 32'd4);
        repeat (30) cycle();

        // Channel 2 one-shot, div 5, already enabled at the write
        ch_enable = 4'b0111;
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 10'd5; cfg_oneshot = 1'b1;
        cycle();
        chk("ch2.armed_after_write", 32'(armed[2]), 32'd1);
        cycles_to_tick(2, 20, n);
        chk("ch2.oneshot_delay", 32'(n), 32'd6);
        chk("ch2.armed_falls", 32'(armed[2]), 32'd0);
        n = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (tick[2]) n++;
        end
        chk("ch2.no_more_ticks", 32'(n), 32'd0);
        chk("ch2.clk_stays_low", 32'(clk_out[2]), 32'd0);

        // Pause channel 0 at count 100
        n = 0;
        for (int k = 0; k < 300; k++) begin
            if (m_rem[0] == 118) break;
            cycle();
        end
        chk("ch0.reached_count100", 32'(m_rem[0]), 32'd118);
        ch_enable[0] = 1'b0;
        for (int k = 0; k < 50; k++) begin
            cycle();
            if (tick[0]) n++;
        end
        chk("ch0.no_tick_paused", 32'(n), 32'd0);
        ch_enable[0] = 1'b1;
        cycles_to_tick(0, 300, n);
        chk("ch0.resume_delay", 32'(n), 32'd118);

        // sync_clear with a coincident write to channel 3 (div 0)
        sync_clear = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd3; cfg_div = 10'd0; cfg_oneshot = 1'b0;
        cycle();
        chk("clear.clk_out", 32'(clk_out), 32'h0);
        chk("clear.armed",   32'(armed),   32'h0);
        chk("clear.tick",    32'(tick),    32'h0);
        ch_enable = 4'b1000;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (tick[3]) n++;
        end
        chk("ch3.tick_every_cycle", 32'(n), 32'd8);

        // Out-of-range channel index is ignored
        ch_enable = 4'b1111;
        cfg_we = 1'b1; cfg_ch = 3'd5; cfg_div = 10'd1; cfg_oneshot = 1'b1;
        repeat (40) cycle();

        // Randomised traffic
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) ch_enable = 4'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cfg_we      = 1'b1;
                cfg_ch      = 3'($urandom_range(0, 7));
                cfg_div     = 10'($urandom_range(0, 12));
                cfg_oneshot = 1'($urandom);
            end
            if ($urandom_range(0, 199) == 0) sync_clear = 1'b1;
            cycle();
        end

        // Asynchronous reset mid-count
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 10'd2; cfg_oneshot = 1'b0;
        ch_enable = 4'b1111;
        repeat (7) cycle();
        #4 reset_n = 1'b0;
        #1;
        model_reset();
        chk("areset.tick",    32'(tick),    32'h0);
        chk("areset.clk_out", 32'(clk_out), 32'h0);
        chk("areset.armed",   32'(armed),   32'h0);
        repeat (2) cycle();
        reset_n = 1'b1;
        ch_enable = 4'b0001;
        cycles_to_tick(0, 300, n);
        chk("areset.default_div", 32'(n), 32'd218);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
